// File: rtl/decryptor_iter.sv
// Iterative AES-128 inverse cipher: forward key expansion to rk10, then one round per clock
// with an on-the-fly backward key walk. Optional key cache: DECRYPTOR_KEY_CACHE_EN.
module decryptor_iter #(
  parameter int NR        = 10,
  parameter bit HOLD_DONE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEYEXP = 3'd1,
    S_INIT   = 3'd2,
    S_ROUND  = 3'd3,
    S_FINAL  = 3'd4
  } state_e;

  if (NR != 10) begin : g_nr_check
    $error("decryptor_iter: only NR=10 (AES-128) is supported");
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = a;
    res = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      res = gmul(res, sq);
    end
    return res;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Byte n sits at bits [127-8n -: 8]; column c = n/4, row r = n%4.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = inv_sbox(s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  state_e       state_q;
  logic [3:0]   rnd_q;
  logic [127:0] st_q;
  logic [127:0] rk_q;

  // rnd_q always holds the Rcon index of the schedule step taken this cycle.
  logic [31:0]  sw_in_d, sw_out_d;
  logic [31:0]  n0_d, n1_d, n2_d, n3_d;
  logic [127:0] rk_next_d, rk_prev_d, isb_d, round_d, final_d;
  logic         hit_d;
  logic [127:0] hit_rk_d;

  assign sw_in_d   = (state_q == S_KEYEXP) ? rk_q[31:0] : (rk_q[31:0] ^ rk_q[63:32]);
  assign sw_out_d  = sub_word({sw_in_d[23:0], sw_in_d[31:24]}) ^ {rcon(rnd_q), 24'h000000};
  assign n0_d      = rk_q[127:96] ^ sw_out_d;
  assign n1_d      = rk_q[95:64] ^ n0_d;
  assign n2_d      = rk_q[63:32] ^ n1_d;
  assign n3_d      = rk_q[31:0] ^ n2_d;
  assign rk_next_d = {n0_d, n1_d, n2_d, n3_d};
  assign rk_prev_d = {rk_q[127:96] ^ sw_out_d, rk_q[95:64] ^ rk_q[127:96],
                      rk_q[63:32] ^ rk_q[95:64], rk_q[31:0] ^ rk_q[63:32]};
  assign isb_d     = inv_shift_sub(st_q);
  assign round_d   = inv_mix_columns(isb_d ^ rk_q);
  assign final_d   = isb_d ^ rk_q;

`ifdef DECRYPTOR_KEY_CACHE_EN
  logic [127:0] cache_key_q;
  logic [127:0] cache_rk_q;
  logic         cache_vld_q;

  assign hit_d    = cache_vld_q && (key == cache_key_q);
  assign hit_rk_d = cache_rk_q;

  // Key cache: remembers the last expanded key and its rk10.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_key_q <= 128'h0;
      cache_rk_q  <= 128'h0;
      cache_vld_q <= 1'b0;
    end else if (state_q == S_IDLE && start && !busy && !hit_d) begin
      cache_key_q <= key;
      cache_vld_q <= 1'b0;
    end else if (state_q == S_KEYEXP && rnd_q == 4'd9) begin
      cache_rk_q  <= rk_next_d;
      cache_vld_q <= 1'b1;
    end else begin
      cache_vld_q <= cache_vld_q;
    end
  end
`else
  assign hit_d    = 1'b0;
  assign hit_rk_d = 128'h0;
`endif

  // Sequencer: key expansion, backward key walk and the round datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rnd_q     <= 4'd0;
      st_q      <= 128'h0;
      rk_q      <= 128'h0;
      plaintext <= 128'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !busy) begin
            st_q <= ciphertext;
            busy <= 1'b1;
            done <= 1'b0;
            if (hit_d) begin
              state_q <= S_INIT;
              rnd_q   <= 4'd9;
              rk_q    <= hit_rk_d;
            end else begin
              state_q <= S_KEYEXP;
              rnd_q   <= 4'd0;
              rk_q    <= key;
            end
          end else if (!HOLD_DONE) begin
            done <= 1'b0;
          end
        end
        S_KEYEXP: begin
          rk_q <= rk_next_d;
          if (rnd_q == 4'd9) begin
            state_q <= S_INIT;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        S_INIT: begin
          st_q    <= st_q ^ rk_q;
          rk_q    <= rk_prev_d;
          rnd_q   <= 4'd8;
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          st_q <= round_d;
          rk_q <= rk_prev_d;
          if (rnd_q == 4'd0) begin
            state_q <= S_FINAL;
          end else begin
            rnd_q <= rnd_q - 4'd1;
          end
        end
        S_FINAL: begin
          plaintext <= final_d;
          done      <= 1'b1;
          busy      <= 1'b0;
          rnd_q     <= 4'd0;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decryptor_iter.sv
// Scoreboard bench for decryptor_iter: FIPS-197 vectors, latency, busy/done timing, reset and
// ignored-start cases, plus a HOLD_DONE=0 instance.
module tb_decryptor_iter;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10_2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam int LAT_MISS = 22;
`ifdef DECRYPTOR_KEY_CACHE_EN
  localparam int LAT_HIT = 12;
`else
  localparam int LAT_HIT = 22;
`endif

  typedef struct {
    logic [127:0] pt;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start, start0;
  logic [127:0] ciphertext, key, pt, pt0;
  logic         busy, done, busy0, done0;
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  exp_t         sb_q[$];
  exp_t         mon_e;
  logic         done_prev = 1'b0;

  decryptor_iter #(.NR(10), .HOLD_DONE(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .ciphertext(ciphertext), .key(key),
    .plaintext(pt), .busy(busy), .done(done)
  );

  decryptor_iter #(.NR(10), .HOLD_DONE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .ciphertext(ciphertext), .key(key),
    .plaintext(pt0), .busy(busy0), .done(done0)
  );

  always #5 clk = ~clk;

  // Period counter: at a negedge, cyc names the current clock period.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every rising done pops one expectation.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 128'd1, 128'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("plaintext", pt, mon_e.pt);
        check("latency_cycle", 128'(cyc), 128'(mon_e.cyc));
      end
    end
    done_prev <= done;
  end

  // Called at a negedge: start is high for the current period, which becomes cycle 0.
  task automatic issue(input logic [127:0] c, input logic [127:0] k, input logic [127:0] p,
                       input int lat, input bit expect_done, output int t0);
    ciphertext = c;
    key        = k;
    start      = 1'b1;
    t0         = cyc;
    if (expect_done) sb_q.push_back('{pt: p, cyc: t0 + lat});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, 128'(done), 128'd1);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int t0;
    rst = 1'b1; start = 1'b0; start0 = 1'b0; ciphertext = 128'h0; key = 128'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_pt", pt, 128'h0);
    check("rst_pt0", pt0, 128'h0);
    rst = 1'b0;
    @(negedge clk);

    // Run 1: FIPS-197 C.1, busy window and done cycle
    issue(C1, K1, P1, LAT_MISS, 1'b1, t0);
    check("t1_busy_c1", 128'(busy), 128'd1);
    wait_until(t0 + 21);
    check("t1_busy_c21", 128'(busy), 128'd1);
    check("t1_done_c21", 128'(done), 128'd0);
    @(negedge clk);
    check("t1_busy_c22", 128'(busy), 128'd0);
    check("t1_done_c22", 128'(done), 128'd1);

    // Run 3: same key again (cache hit when enabled)
    @(negedge clk);
    issue(C1, K1, P1, LAT_HIT, 1'b1, t0);
    wait_done("t3_done_seen");

    // Run 2: Appendix B vector, rk10 after expansion
    @(negedge clk);
    issue(C2, K2, P2, LAT_MISS, 1'b1, t0);
    wait_until(t0 + 11);
    check("t2_rk10", dut.rk_q, RK10_2);
    wait_done("t2_done_seen");

    // Run 4: starts while busy are ignored
    @(negedge clk);
    issue(C1, K1, P1, LAT_MISS, 1'b1, t0);
    wait_until(t0 + 3);
    ciphertext = C2; key = K2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 15);
    ciphertext = C2; key = K2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4_done_seen");

    // Run 5: reset mid-operation, then a fresh run
    @(negedge clk);
    issue(C2, K2, P2, LAT_MISS, 1'b0, t0);
    wait_until(t0 + 14);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy_after_rst", 128'(busy), 128'd0);
    check("t5_done_after_rst", 128'(done), 128'd0);
    check("t5_pt_after_rst", pt, 128'h0);
    issue(C2, K2, P2, LAT_MISS, 1'b1, t0);
    wait_done("t5_done_seen");

    // Run 6: start in the done cycle is accepted
    issue(C1, K1, P1, LAT_MISS, 1'b1, t0);
    check("t6_done_dropped", 128'(done), 128'd0);
    check("t6_pt_held", pt, P2);
    wait_done("t6a_done_seen");
    issue(C1, K1, P1, LAT_HIT, 1'b1, t0);
    wait_done("t6b_done_seen");

    // HOLD_DONE=0 instance: one-cycle done pulse
    @(negedge clk);
    ciphertext = C1; key = K1; start0 = 1'b1; t0 = cyc;
    @(negedge clk);
    start0 = 1'b0;
    wait_until(t0 + 21);
    check("h0_done_c21", 128'(done0), 128'd0);
    @(negedge clk);
    check("h0_done_c22", 128'(done0), 128'd1);
    check("h0_pt_c22", pt0, P1);
    @(negedge clk);
    check("h0_done_c23", 128'(done0), 128'd0);
    check("h0_pt_c23", pt0, P1);

    repeat (3) @(negedge clk);
    check("sb_empty", 128'(sb_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
